uart_mmio_controller: RTL and testbench

CPU-side UART peripheral: the DUT-facing end of the serial link that the testbench UART model drives and monitors. It serialises bytes written by the core onto txd and deserialises bytes arriving on rxd, each direction buffered by a small FIFO. The core reaches it through a byte-wide memory-mapped register port with a data register at offset 0 and a status register at offset 5. It sits behind the CPU's MMIO decoder.

---
 rtl/uart_mmio_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_mmio_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_controller.sv
// UART peripheral with a byte-wide MMIO register port (data at offset 0,
// status at offset 5) and a small FIFO in each direction.
module uart_mmio_controller #(
  parameter int CLK_FREQ   = 80_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic       rx_irq
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_ONE   = CNT_W'(1);
  localparam logic [CNT_F-1:0] FULL      = CNT_F'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNT_F-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  state_t           tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CNT_W-1:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic             txd_q, txd_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic             ovr_q, ovr_d, fe_q, fe_d, ack_q, ack_d, irq_q, irq_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             wr0, rd0, rd5, tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop, rx_done, rx_fall;
  logic [7:0]       status;

  assign wr0      = bus_req && bus_we && (bus_addr == 3'd0);
  assign rd0      = bus_req && !bus_we && (bus_addr == 3'd0);
  assign rd5      = bus_req && !bus_we && (bus_addr == 3'd5);
  assign tx_full  = (tx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_fall  = rx_prev_q && !rx_s2_q;
  assign status   = {1'b0, tx_empty && (tx_st_q == S_IDLE), !tx_full, 1'b0,
                     fe_q, 1'b0, ovr_q, !rx_empty};

  // Transmitter: pops the FIFO head whenever a frame can start, including
  // straight out of STOP so queued bytes go out without an idle gap.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem[tx_rd_q];
          tx_st_d  = S_START;
          tx_div_d = '0;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tx_div_q == DIV_LAST) begin
          tx_st_d  = S_DATA;
          tx_div_d = '0;
          tx_bit_d = '0;
          txd_d    = tx_sh_q[0];
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
      S_DATA: begin
        if (tx_div_q == DIV_LAST) begin
          tx_div_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = tx_sh_q >> 1;
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
      default: begin
        if (tx_div_q == DIV_LAST) begin
          tx_div_d = '0;
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_mem[tx_rd_q];
            tx_st_d = S_START;
            txd_d   = 1'b0;
          end else begin
            tx_st_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          tx_div_d = tx_div_q + DIV_ONE;
        end
      end
    endcase
  end

  // Receiver: synchronise rxd, detect the start edge, sample mid-bit.
  always_comb begin
    rx_s1_d   = rxd;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    rx_st_d   = rx_st_q;
    rx_div_d  = rx_div_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_done   = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_st_d  = S_START;
          rx_div_d = '0;
        end
      end
      S_START: begin
        if (rx_div_q == HALF_LAST) begin
          rx_div_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
      S_DATA: begin
        if (rx_div_q == DIV_LAST) begin
          rx_div_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
      default: begin
        if (rx_div_q == DIV_LAST) begin
          rx_st_d = S_IDLE;
          rx_done = 1'b1;
        end else begin
          rx_div_d = rx_div_q + DIV_ONE;
        end
      end
    endcase
  end

  // FIFO bookkeeping, sticky error flags and the registered bus response.
  always_comb begin
    tx_push  = wr0 && (!tx_full || tx_pop);
    rx_pop   = rd0 && !rx_empty;
    rx_push  = rx_done && rx_s2_q && (!rx_full || rx_pop);
    tx_cnt_d = tx_cnt_q + CNT_F'(tx_push) - CNT_F'(tx_pop);
    rx_cnt_d = rx_cnt_q + CNT_F'(rx_push) - CNT_F'(rx_pop);
    tx_wr_d  = tx_wr_q + PTR_W'(tx_push);
    tx_rd_d  = tx_rd_q + PTR_W'(tx_pop);
    rx_wr_d  = rx_wr_q + PTR_W'(rx_push);
    rx_rd_d  = rx_rd_q + PTR_W'(rx_pop);
    // A status read clears the flags, but an event in the same cycle wins.
    ovr_d    = (ovr_q && !rd5) || (rx_done && rx_s2_q && rx_full && !rx_pop);
    fe_d     = (fe_q && !rd5) || (rx_done && !rx_s2_q);
    irq_d    = (rx_cnt_d != '0);
    ack_d    = bus_req;
    rdata_d  = 8'h00;
    if (rx_pop)   rdata_d = rx_mem[rx_rd_q];
    else if (rd5) rdata_d = status;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st_q  <= S_IDLE;
      tx_div_q <= '0;
      tx_bit_q <= '0;
      txd_q    <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_div_q <= '0;
      rx_bit_q <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;
      txd_q    <= txd_d;
      rx_st_q  <= rx_st_d;
      rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // Datapath storage; the synchroniser keeps sampling through reset so a line
  // held low by a cut-off frame is not mistaken for a fresh start edge.
  always_ff @(posedge clk) begin
    rx_s1_q   <= rx_s1_d;
    rx_s2_q   <= rx_s2_d;
    rx_prev_q <= rx_prev_d;
    tx_sh_q   <= tx_sh_d;
    rx_sh_q   <= rx_sh_d;
    if (tx_push) tx_mem[tx_wr_q] <= bus_wdata;
    if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
  end

  assign txd       = txd_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign rx_irq    = irq_q;

endmodule

// File: tb/tb_uart_mmio_controller.sv
// Bench for uart_mmio_controller at DIV = 8 (CLK_FREQ = 8, BAUD = 1).
module tb_uart_mmio_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic       bus_req;
  logic       bus_we;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       rx_irq;

  uart_mmio_controller #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  typedef struct { bit chk; logic [7:0] exp; string name; } bexp_t;
  typedef struct { bit we; logic [2:0] addr; logic [7:0] wdata; bit chk; logic [7:0] exp; string name; } vec_t;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         frames_done = 0;
  bexp_t      exp_q[$];
  logic [7:0] tx_exp_q[$];
  int         tx_start_q[$];
  vec_t       vecs[8];

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus request; the expected read data goes to the scoreboard.
  task automatic bus(input bit we, input logic [2:0] a, input logic [7:0] wd,
                     input bit chk, input logic [7:0] exp, input string nm);
    bexp_t e;
    e.chk = chk; e.exp = exp; e.name = nm;
    exp_q.push_back(e);
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd;
    tick(1);
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(8);
    end
    rxd = stop;
    tick(8);
    rxd = 1'b1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int k = 0; k < budget && frames_done < target; k++) tick(1);
    check("tx_frames_done", frames_done, target);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus scoreboard: every ack consumes one expectation.
  bexp_t mon_e;
  always @(negedge clk) begin
    if (bus_ack === 1'b1) begin
      check("bus_ack_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) check(mon_e.name, bus_rdata, mon_e.exp);
      end
    end
  end

  // TX line monitor: checks every cycle of each frame against the expected byte.
  int         tm_bad;
  bit         tm_have, tm_abort;
  logic [7:0] tm_exp, tm_got;
  logic       tm_eb;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        tx_start_q.push_back(cyc);
        check("tx_frame_expected", int'(tx_exp_q.size() != 0), 1);
        tm_have = (tx_exp_q.size() != 0);
        tm_exp = tm_have ? tx_exp_q.pop_front() : 8'h00;
        tm_bad = 0; tm_abort = 0; tm_got = 8'h00;
        for (int i = 0; i < 80; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            tm_abort = 1;
            break;
          end
          if (i < 8)        tm_eb = 1'b0;
          else if (i >= 72) tm_eb = 1'b1;
          else              tm_eb = tm_exp[(i - 8) / 8];
          if (txd !== tm_eb) tm_bad++;
          if (i >= 8 && i < 72 && (i % 8) == 4) tm_got[(i - 8) / 8] = txd;
        end
        if (!tm_abort && tm_have) begin
          check("tx_frame_timing", tm_bad, 0);
          check("tx_frame_byte", tm_got, tm_exp);
          frames_done++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ack_cyc;
  int base;
  initial begin
    vecs[0] = '{1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_after_reset"};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, "rd_data_empty"};
    vecs[2] = '{1'b0, 3'd3, 8'h00, 1'b1, 8'h00, "rd_off3"};
    vecs[3] = '{1'b1, 3'd3, 8'hAA, 1'b0, 8'h00, "wr_off3"};
    vecs[4] = '{1'b1, 3'd5, 8'hFF, 1'b0, 8'h00, "wr_status"};
    vecs[5] = '{1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_after_ignored_wr"};
    vecs[6] = '{1'b0, 3'd7, 8'h00, 1'b1, 8'h00, "rd_off7"};
    vecs[7] = '{1'b0, 3'd1, 8'h00, 1'b1, 8'h00, "rd_off1"};

    rst = 1'b0; rxd = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00;
    tick(3);
    check("rst_txd", txd, 1);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_irq", rx_irq, 0);
    rst = 1'b1;
    tick(1);

    // Register map on an idle peripheral, requests issued back-to-back.
    for (int i = 0; i < 8; i++)
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp, vecs[i].name);
    tick(4);
    check("idle_txd", txd, 1);

    // Single TX byte.
    tx_start_q.delete();
    base = frames_done;
    tx_exp_q.push_back(8'h55);
    bus(1'b1, 3'd0, 8'h55, 1'b0, 8'h00, "wr_55");
    ack_cyc = cyc;
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h20, "stat_tx_busy");
    wait_frames(base + 1, 200);
    check("tx_start_within_2", int'(tx_start_q.size() != 0 && tx_start_q[0] - ack_cyc <= 2), 1);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_tx_done");

    // The transmitter takes A1 the cycle after it lands, so A2..A5 fill the
    // FIFO and A6 is the write that is dropped.
    tx_start_q.delete();
    base = frames_done;
    for (int i = 1; i <= 5; i++) tx_exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 1; i <= 5; i++) bus(1'b1, 3'd0, 8'hA0 + 8'(i), 1'b0, 8'h00, "wr_burst");
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h00, "stat_tx_full");
    bus(1'b1, 3'd0, 8'hA6, 1'b0, 8'h00, "wr_dropped");
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h00, "stat_still_full");
    wait_frames(base + 5, 600);
    for (int i = 0; i < 4; i++)
      check("tx_contiguous", (tx_start_q.size() > i + 1) ? tx_start_q[i + 1] - tx_start_q[i] : -1, 80);
    tick(2);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_burst_done");

    // RX normal frame.
    send_rx(8'h3C, 1'b1);
    tick(3);
    check("rx_irq_set", rx_irq, 1);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h61, "stat_rx_avail");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h3C, "rd_rx_3c");
    tick(2);
    check("rx_irq_clear", rx_irq, 0);
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, "rd_rx_empty");

    // False start glitch.
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(30);
    check("glitch_irq", rx_irq, 0);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_after_glitch");

    // Framing error.
    send_rx(8'hA5, 1'b0);
    tick(3);
    check("frm_irq", rx_irq, 0);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h68, "stat_framing");
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_framing_cleared");

    // Overrun: five frames, no reads.
    for (int i = 1; i <= 5; i++) send_rx(8'(i * 8'h11), 1'b1);
    tick(3);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h63, "stat_overrun");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h11, "rd_ovr_0");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h22, "rd_ovr_1");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h33, "rd_ovr_2");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h44, "rd_ovr_3");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, "rd_ovr_empty");
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_overrun_cleared");

    // Reset during TX data bit 3 (a 0 for 0x96) and mid RX frame.
    tx_exp_q.push_back(8'h96);
    fork
      send_rx(8'hF0, 1'b1);
      begin
        bus(1'b1, 3'd0, 8'h96, 1'b0, 8'h00, "wr_96");
        tick(35);
        check("tx_bit3_before_rst", txd, 0);
        rst = 1'b0;
        tick(1);
        check("txd_after_rst", txd, 1);
        check("ack_after_rst", bus_ack, 0);
        tick(1);
        rst = 1'b1;
      end
    join
    tx_exp_q.delete();
    tick(20);
    check("irq_after_midrst", rx_irq, 0);
    check("txd_idle_after_midrst", txd, 1);
    bus(1'b0, 3'd5, 8'h00, 1'b1, 8'h60, "stat_after_midrst");
    bus(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, "rd_after_midrst");

    tick(5);
    check("bus_acks_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
